// File: rtl/rv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv_pkg: core-wide constants shared with the memory arbiter.
//   XLEN           data width
//   MEM_LEN        physical memory address width
//   ADDRESS_GATE   addresses below this use ADDRESS_DEC_LT, others ADDRESS_DEC_GE
//   ADDRESS_DEC_LT offset removed from low-window addresses
//   ADDRESS_DEC_GE offset removed from high-window addresses
//
// rv_mem_arbiter: shares one fixed-latency unified memory between the
// instruction-fetch port and the load/store port, one transaction at a time.
//   clk_i / arst_i           clock, asynchronous active-high reset
//   instr_req_i/addr_i       fetch request (held until instr_gnt_o)
//   instr_gnt_o              one-cycle accept pulse
//   instr_rvalid_o/rdata_o/err_o  fetch response (err qualified by rvalid)
//   data_req_i/we_i/be_i/addr_i/wdata_i  load/store request
//   data_gnt_o               one-cycle accept pulse
//   data_rvalid_o/rdata_o/err_o   load/store response (rdata 0 for writes)
//   mem_req_o/we_o/be_o/addr_o/wdata_o  memory strobe, only in the grant cycle
//   mem_rdata_i              read data, valid MEM_LAT cycles after mem_req_o
// ---------------------------------------------------------------------------
package rv_pkg;
  localparam int          XLEN           = 32;
  localparam int          MEM_LEN        = 20;
  localparam logic [31:0] ADDRESS_GATE   = 32'h000F_FFFF;
  localparam logic [31:0] ADDRESS_DEC_LT = 32'h0001_0094;
  localparam logic [31:0] ADDRESS_DEC_GE = 32'h7FEF_FDB0;
endpackage

module rv_mem_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int          XLEN    = rv_pkg::XLEN,
  parameter int          MEM_LEN = rv_pkg::MEM_LEN
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [XLEN-1:0]      instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [XLEN/8-1:0]    data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [XLEN-1:0]      data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [XLEN-1:0]      data_rdata_o,
  output logic                 data_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  output logic [MEM_LEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  input  logic [XLEN-1:0]      mem_rdata_i
);

  // Counter holds at most MEM_LAT-1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            owner_q;
  logic            we_q;
  logic            err_q;
  logic            last_owner_q;

  // -------------------------------------------------------------------------
  // Address translation, one instance per requester (index 0 instr, 1 data).
  // The subtraction is done 33 bits wide so bit 32 is the borrow.
  // -------------------------------------------------------------------------
  logic [31:0]        req_addr [2];
  logic [MEM_LEN-1:0] phys     [2];
  logic [1:0]         addr_err;

  assign req_addr[0] = instr_addr_i;
  assign req_addr[1] = data_addr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_xlate
    logic [31:0] dec;
    logic [32:0] diff;
    assign dec          = (req_addr[gi] < rv_pkg::ADDRESS_GATE) ? rv_pkg::ADDRESS_DEC_LT
                                                                : rv_pkg::ADDRESS_DEC_GE;
    assign diff         = {1'b0, req_addr[gi]} - {1'b0, dec};
    assign phys[gi]     = diff[MEM_LEN-1:0];
    // Any set bit above the physical width means the window overflowed.
    assign addr_err[gi] = diff[32] | (|diff[31:MEM_LEN]);
  end

  // -------------------------------------------------------------------------
  // Arbitration. Grants are only possible in IDLE and are suppressed while
  // reset is asserted so every output reads 0 during reset.
  // -------------------------------------------------------------------------
  logic win;
  logic any_req;
  logic grant;
  logic win_err;
  logic win_we;

  always_comb begin
    win = OWN_INSTR;
    if (instr_req_i && data_req_i) begin
      win = ~last_owner_q;
    end else if (data_req_i) begin
      win = OWN_DATA;
    end
  end

  assign any_req = instr_req_i | data_req_i;
  assign grant   = (state_q == ST_IDLE) && !arst_i && any_req;
  assign win_err = addr_err[win];
  assign win_we  = (win == OWN_DATA) && data_we_i;

  assign instr_gnt_o = grant && (win == OWN_INSTR);
  assign data_gnt_o  = grant && (win == OWN_DATA);

  // Memory strobe only for a successful grant; everything else stays 0.
  assign mem_req_o   = grant && !win_err;
  assign mem_we_o    = mem_req_o && win_we;
  assign mem_be_o    = !mem_req_o ? '0 : ((win == OWN_DATA) ? data_be_i : '1);
  assign mem_addr_o  = mem_req_o ? phys[win] : '0;
  assign mem_wdata_o = (mem_req_o && (win == OWN_DATA)) ? data_wdata_i : '0;

  // -------------------------------------------------------------------------
  // Response, presented in RESP. Read data passes straight through from the
  // memory because it is valid exactly in that cycle.
  // -------------------------------------------------------------------------
  logic resp;
  logic rd_ok;

  assign resp  = (state_q == ST_RESP);
  assign rd_ok = !we_q && !err_q;

  assign instr_rvalid_o = resp && (owner_q == OWN_INSTR);
  assign instr_err_o    = instr_rvalid_o && err_q;
  assign instr_rdata_o  = (instr_rvalid_o && rd_ok) ? mem_rdata_i : '0;

  assign data_rvalid_o  = resp && (owner_q == OWN_DATA);
  assign data_err_o     = data_rvalid_o && err_q;
  assign data_rdata_o   = (data_rvalid_o && rd_ok) ? mem_rdata_i : '0;

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_INSTR;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_owner_q <= OWN_DATA;   // first tie after reset goes to instr
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q      <= win;
            we_q         <= win_we;
            err_q        <= win_err;
            last_owner_q <= win;
            // An address error never touches memory, so answer next cycle.
            if (win_err || (MEM_LAT == 1)) begin
              state_q <= ST_RESP;
            end else begin
              cnt_q   <= CW'(MEM_LAT - 1);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
